// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data requesters.
// Data wins ties unless fetch has lost STARVE_MAX grants in a row; one transaction per MEM_LATENCY+3 cycles.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant_id
);
  localparam int               CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [2:0]       WAIT_INIT  = 3'(MEM_LATENCY - 1);
  localparam logic [1:0]       GNT_NONE   = 2'b00;
  localparam logic [1:0]       GNT_IF     = 2'b01;
  localparam logic [1:0]       GNT_DM     = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [2:0]        wait_q, wait_d;
  logic [1:0]        grant_q, grant_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              win_if;

  // Fetch wins when alone, or when it has been passed over STARVE_MAX times.
  always_comb begin
    win_if = if_req && (!dm_req || (starve_q == STARVE_LIM));
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    grant_d     = grant_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (win_if) begin
            grant_d    = GNT_IF;
            we_d       = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end else begin
            grant_d     = GNT_DM;
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_req && (starve_q < STARVE_LIM)) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = WAIT_INIT;
      end
      WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = RESP;
          if (grant_q == GNT_IF) begin
            if_ack_d = 1'b1;
            if (!we_q) if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RESP: begin
        // Requests are deliberately not sampled here, so a held req is never re-granted on its ack.
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      grant_q     <= GNT_NONE;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queued requester drivers, a transaction-level reference model
// predicting grants/issues/acks, and a monitor that pops and compares whenever the DUT responds.
module tb_mem_port_arbiter;
  localparam int ML   = 3;
  localparam int SMAX = 4;

  logic        clk, rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant_id;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int gap;} tx_t;
  typedef struct {int cyc; logic [31:0] addr; logic we; logic [31:0] data;} exp_t;

  tx_t         if_txq[$], dm_txq[$];
  exp_t        ifq[$], dmq[$], memq[$];
  int          ack_log[$], ack_cyc_log[$];
  int          tests = 0, fails = 0, cyc = 0, exp_grant = 0;
  bit          if_busy = 0, dm_busy = 0;
  logic [31:0] phys[64];
  logic [31:0] model_mem[64];
  logic [31:0] pipe[ML];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name, input string act, input string req);
    tests++;
    fails++;
    $display("FAIL %s: got %s, required %s (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_outputs_zero();
    check("rst_if_ack", 32'(if_ack), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_ack", 32'(dm_ack), 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_txq.size() > 0 || dm_txq.size() > 0 || if_busy || dm_busy ||
            ifq.size() > 0 || dmq.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) flag("drain_timeout", "transactions outstanding", "all acked");
    repeat (2) @(negedge clk);
  endtask

  // Synchronous memory: address captured on the mem_en edge, data appears ML cycles after the strobe cycle.
  initial begin : memory
    for (int i = 0; i < 64; i++) phys[i] = init_word(i);
    for (int i = 0; i < ML; i++) pipe[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) phys[mem_addr[5:0]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? phys[mem_addr[5:0]] : $urandom;
      for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_rdata = pipe[ML-1];

  initial begin : drv_if
    tx_t t;
    int  waitc;
    if_req = 1'b0; if_addr = 32'h0; waitc = 0;
    forever begin
      @(negedge clk);
      if (if_busy && if_ack) if_busy = 0;
      if (if_busy) begin
        waitc++;
        if (waitc > 100) begin
          flag("if_ack_timeout", "no if_ack", "if_ack");
          if_busy = 0;
        end
      end
      if (!if_busy) begin
        if_req = 1'b0;
        if (if_txq.size() > 0) begin
          if (if_txq[0].gap > 0) if_txq[0].gap--;
          else begin
            t = if_txq.pop_front();
            if_addr = t.addr; if_req = 1'b1; if_busy = 1; waitc = 0;
          end
        end
      end
    end
  end

  initial begin : drv_dm
    tx_t t;
    int  waitc;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; waitc = 0;
    forever begin
      @(negedge clk);
      if (dm_busy && dm_ack) dm_busy = 0;
      if (dm_busy) begin
        waitc++;
        if (waitc > 100) begin
          flag("dm_ack_timeout", "no dm_ack", "dm_ack");
          dm_busy = 0;
        end
      end
      if (!dm_busy) begin
        dm_req = 1'b0;
        if (dm_txq.size() > 0) begin
          if (dm_txq[0].gap > 0) dm_txq[0].gap--;
          else begin
            t = dm_txq.pop_front();
            dm_we = t.we; dm_addr = t.addr; dm_wdata = t.data; dm_req = 1'b1;
            dm_busy = 1; waitc = 0;
          end
        end
      end
    end
  end

  // Transaction-level model: a grant occupies the memory for ML+3 edges; issue follows the grant edge,
  // ack arrives ML+1 edges after it; fetch is forced through after SMAX consecutive losses.
  initial begin : model
    int          next_free, grant_end, starve, idx;
    bit          win_if;
    logic [31:0] last_if, last_dm;
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    next_free = 0; grant_end = -1; starve = 0; last_if = 0; last_dm = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ifq.delete(); dmq.delete(); memq.delete();
        exp_grant = 0; next_free = 0; grant_end = -1; starve = 0;
        last_if = 32'h0; last_dm = 32'h0;
      end else begin
        cyc++;
        if (cyc == grant_end) exp_grant = 0;
        if (cyc >= next_free && (if_req || dm_req)) begin
          win_if = if_req && (!dm_req || starve == SMAX);
          if (win_if) starve = 0;
          else if (if_req && starve < SMAX) starve++;
          next_free = cyc + ML + 3;
          grant_end = cyc + ML + 2;
          if (win_if) begin
            idx = int'(if_addr[5:0]);
            last_if = model_mem[idx];
            exp_grant = 1;
            memq.push_back('{cyc, if_addr, 1'b0, 32'h0});
            ifq.push_back('{cyc + ML + 1, 32'h0, 1'b0, last_if});
          end else begin
            idx = int'(dm_addr[5:0]);
            exp_grant = 2;
            if (dm_we) model_mem[idx] = dm_wdata;
            else last_dm = model_mem[idx];
            memq.push_back('{cyc, dm_addr, dm_we, dm_wdata});
            dmq.push_back('{cyc + ML + 1, 32'h0, 1'b0, last_dm});
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [31:0] hold_if, hold_dm;
    hold_if = 32'h0; hold_dm = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_if = 32'h0; hold_dm = 32'h0;
      end else begin
        check("grant_id", 32'(grant_id), 32'(exp_grant));
        if (mem_en) begin
          if (memq.size() == 0) flag("mem_en_unexpected", "mem_en=1", "no pending issue");
          else begin
            e = memq.pop_front();
            check("issue_cycle", 32'(cyc), 32'(e.cyc));
            check("mem_addr", mem_addr, e.addr);
            check("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) check("mem_wdata", mem_wdata, e.data);
          end
        end else begin
          check("mem_we_idle", 32'(mem_we), 32'h0);
          if (memq.size() > 0 && memq[0].cyc < cyc) begin
            flag("issue_missing", "mem_en=0", "mem_en=1");
            void'(memq.pop_front());
          end
        end
        if (if_ack) begin
          ack_log.push_back(1); ack_cyc_log.push_back(cyc);
          if (ifq.size() == 0) flag("if_ack_unexpected", "if_ack=1", "no pending fetch");
          else begin
            e = ifq.pop_front();
            check("if_ack_cycle", 32'(cyc), 32'(e.cyc));
            check("if_rdata", if_rdata, e.data);
            hold_if = e.data;
          end
        end else begin
          check("if_rdata_hold", if_rdata, hold_if);
          if (ifq.size() > 0 && ifq[0].cyc < cyc) begin
            flag("if_ack_missing", "if_ack=0", "if_ack=1");
            void'(ifq.pop_front());
          end
        end
        if (dm_ack) begin
          ack_log.push_back(2); ack_cyc_log.push_back(cyc);
          if (dmq.size() == 0) flag("dm_ack_unexpected", "dm_ack=1", "no pending data access");
          else begin
            e = dmq.pop_front();
            check("dm_ack_cycle", 32'(cyc), 32'(e.cyc));
            check("dm_rdata", dm_rdata, e.data);
            hold_dm = e.data;
          end
        end else begin
          check("dm_rdata_hold", dm_rdata, hold_dm);
          if (dmq.size() > 0 && dmq[0].cyc < cyc) begin
            flag("dm_ack_missing", "dm_ack=0", "dm_ack=1");
            void'(dmq.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int n, rel;
    int exp_order[8] = '{2, 2, 2, 2, 1, 2, 2, 1};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;

    // Single fetch of the preloaded word.
    @(posedge clk); #1;
    if_txq.push_back('{1'b0, 32'h10, 32'h0, 0});
    wait_idle();
    check("single_fetch_rdata", if_rdata, 32'hDEADBEEF);

    // Simultaneous requests: data first, fetch one full transaction later.
    ack_log.delete(); ack_cyc_log.delete();
    @(posedge clk); #1;
    if_txq.push_back('{1'b0, 32'h11, 32'h0, 0});
    dm_txq.push_back('{1'b0, 32'h12, 32'h0, 0});
    wait_idle();
    check("simul_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("simul_first_owner", 32'(ack_log[0]), 32'd2);
      check("simul_second_owner", 32'(ack_log[1]), 32'd1);
      check("simul_spacing", 32'(ack_cyc_log[1] - ack_cyc_log[0]), 32'(ML + 3));
    end

    // Both requesters held high: fetch forced through after SMAX data grants.
    ack_log.delete(); ack_cyc_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) dm_txq.push_back('{1'b0, 32'(20 + i), 32'h0, 0});
    for (int i = 0; i < 2; i++) if_txq.push_back('{1'b0, 32'(40 + i), 32'h0, 0});
    wait_idle();
    check("starve_ack_count", 32'(ack_log.size()), 32'd8);
    if (ack_log.size() == 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("starve_order_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
    end

    // Write then read back the same word.
    @(posedge clk); #1;
    dm_txq.push_back('{1'b1, 32'h20, 32'h12345678, 0});
    dm_txq.push_back('{1'b0, 32'h20, 32'h0, 0});
    wait_idle();
    check("write_read_back", dm_rdata, 32'h12345678);

    // Reset while the fetch sits in WAIT; a fresh transaction must follow release.
    @(posedge clk); #1;
    if_txq.push_back('{1'b0, 32'h05, 32'h0, 0});
    n = 0;
    while (!mem_en && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) flag("rst_test_issue_timeout", "no mem_en", "mem_en");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_outputs_zero();
    @(negedge clk); @(negedge clk);
    rel = cyc;
    rst = 1'b0;
    n = 0;
    while (!if_ack && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) flag("rst_fresh_ack_timeout", "no if_ack", "if_ack");
    else check("rst_fresh_ack_cycle", 32'(cyc), 32'(rel + ML + 2));
    wait_idle();

    // Back-to-back fetches with req held: acks spaced ML+3 cycles.
    ack_cyc_log.delete(); ack_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if_txq.push_back('{1'b0, 32'(i * 7), 32'h0, 0});
    wait_idle();
    check("b2b_ack_count", 32'(ack_cyc_log.size()), 32'd3);
    if (ack_cyc_log.size() == 3) begin
      check("b2b_spacing_0", 32'(ack_cyc_log[1] - ack_cyc_log[0]), 32'(ML + 3));
      check("b2b_spacing_1", 32'(ack_cyc_log[2] - ack_cyc_log[1]), 32'(ML + 3));
    end

    // Randomised mixed traffic against the model.
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if_txq.push_back('{1'b0, 32'($urandom_range(0, 63)), 32'h0, int'($urandom_range(0, 3))});
      dm_txq.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), 32'($urandom),
                         int'($urandom_range(0, 3))});
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch and data-access paths of the KGP-RISC core. Each path sees its own request/acknowledge port, and the arbiter serialises accesses through a small FSM. Data access has priority, with a starvation guard for fetch. It sits between the core datapath and the unified memory block, and exposes the current grant for bench observation.

## Interface
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from the `mem_en` cycle to valid `mem_rdata` (legal range 1–7)
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  DATA_W  fetched word
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle pulse; dm_rdata valid in the same cycle (reads)
- dm_rdata  out  DATA_W  read data
- mem_en, mem_we  out  1 each  memory strobe / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- grant_id  out  2  00 none, 01 fetch, 10 data (registered owner of the current transaction)

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - Samples if_req and dm_req on each rising edge.
  - If either is high, it latches the winner's address, we and wdata, sets grant_id, and goes to ISSUE.
- **Arbitration**
  - Only dm requesting: dm wins. Only if requesting: if wins.
  - Both requesting: dm wins unless starve_cnt == STARVE_MAX, in which case if wins.
- **starve_cnt**
  - Width is clog2(STARVE_MAX+1).
  - Increments when dm wins while if_req is high.
  - Clears whenever if wins.
  - Saturates at STARVE_MAX.
- **ISSUE**
  - Exactly one cycle: mem_en=1, with mem_we, mem_addr and mem_wdata taken from the latched request.
  - Goes to WAIT.
- **WAIT**
  - Counts down MEM_LATENCY−1 further cycles (0 cycles when MEM_LATENCY=1).
  - In its final cycle, mem_rdata is registered into the winner's rdata register.
  - Goes to RESP.
- **RESP**
  - Exactly one cycle: the winner's ack=1.
  - No sampling of requests happens in RESP, so a request still held in the ack cycle is never re-granted.
  - Goes to IDLE. grant_id returns to 00 in IDLE.
- **Writes**
  - Follow the same state path, so ack timing is identical to reads.
  - The rdata register of the requester is not updated on a write.
- **Memory outputs outside ISSUE**
  - mem_en=0 and mem_we=0.
  - mem_addr and mem_wdata hold their last values.
- **rdata outputs** hold between acks.

## Timing
- **Reset:** all outputs 0, state IDLE, starve_cnt 0, rdata registers 0.
  - Asserting rst at any point, including ISSUE/WAIT/RESP, aborts the transaction immediately.
  - No ack is issued for the aborted transaction. A write already strobed may have reached memory.
- **Latency:** with req first sampled high at edge E0:
  - ISSUE is the cycle after E0.
  - ack is high in cycle E0 + MEM_LATENCY + 2. With MEM_LATENCY=1, ack arrives 3 cycles after the sampling edge.
- **Throughput:** one transaction per MEM_LATENCY+3 cycles.
  - A requester may keep req high after ack to chain transactions; it is re-sampled in the following IDLE cycle.
- **Request changes:** a requester must not drop or change req or its fields before ack.
  - Changes after the sampling edge are ignored, because fields are latched.
- **Simultaneous request edge:** the priority rule above applies.
  - The loser keeps waiting with req high and is granted at the next IDLE.
  - This guarantees fetch is served within STARVE_MAX+1 grants.

## Test plan
- **Single fetch**
  - Stimulus: MEM_LATENCY=1, memory word[0x10]=0xDEADBEEF, if_req at edge 0.
  - Expected: mem_en high cycle 1 with addr 0x10; if_ack high cycle 3 with if_rdata=0xDEADBEEF; dm_ack stays 0.
- **Simultaneous read**
  - Stimulus: if_req and dm_req rise together.
  - Expected: dm served first (dm_ack cycle 3, grant_id=10); fetch ack in cycle 7 (grant_id=01).
- **Starvation guard**
  - Stimulus: STARVE_MAX=4; dm_req and if_req held high continuously.
  - Expected: grant order is dm, dm, dm, dm, if, dm…; starve_cnt clears after the if grant.
- **Write then read**
  - Stimulus: dm write 0x12345678 to 0x20, then dm read from 0x20.
  - Expected: first ack leaves dm_rdata unchanged; second dm_ack returns 0x12345678.
- **Reset mid-transaction**
  - Stimulus: MEM_LATENCY=3; assert rst during the WAIT cycle.
  - Expected: all outputs 0 asynchronously with no ack; after release with req still high, a fresh full transaction completes (ack 5 cycles after the first sampling edge).
- **Latency parameter**
  - Stimulus: MEM_LATENCY=3, back-to-back fetches with req held high.
  - Expected: acks spaced exactly 6 cycles apart.
